// File: rtl/toy_mem_pkg.sv
// Shared defaults and request type for the toy memory request adapter.
package toy_mem_pkg;

    localparam int TOY_ADDR_WIDTH = 32;
    localparam int TOY_DATA_WIDTH = 32;

    typedef struct packed {
        logic [TOY_ADDR_WIDTH-1:0]   addr;
        logic                        wr_en;
        logic [TOY_DATA_WIDTH-1:0]   wr_data;
        logic [TOY_DATA_WIDTH/8-1:0] wr_byte_en;
    } toy_mem_req_t;

    // Pointer width that stays legal for a single-entry buffer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/toy_mem_req_adapter_if.sv
// Request, response and memory-side signals of the adapter, with one modport per party.
interface toy_mem_req_adapter_if import toy_mem_pkg::*; #(
    parameter int ADDR_WIDTH = TOY_ADDR_WIDTH,
    parameter int DATA_WIDTH = TOY_DATA_WIDTH
);
    logic                    req_vld;
    logic                    req_rdy;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_wr_en;
    logic [DATA_WIDTH-1:0]   req_wr_data;
    logic [DATA_WIDTH/8-1:0] req_wr_byte_en;

    logic                    resp_vld;
    logic                    resp_rdy;
    logic [DATA_WIDTH-1:0]   resp_data;

    logic                    mem_en;
    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wr_data;
    logic [DATA_WIDTH/8-1:0] mem_wr_byte_en;
    logic [DATA_WIDTH-1:0]   mem_rd_data;

    modport host (
        output req_vld, req_addr, req_wr_en, req_wr_data, req_wr_byte_en, resp_rdy,
        input  req_rdy, resp_vld, resp_data
    );

    modport adapter (
        input  req_vld, req_addr, req_wr_en, req_wr_data, req_wr_byte_en, resp_rdy,
        input  mem_rd_data,
        output req_rdy, resp_vld, resp_data,
        output mem_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_byte_en
    );

    modport mem (
        input  mem_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_byte_en,
        output mem_rd_data
    );

endinterface

// File: rtl/toy_mem_model.sv
// Word-organised memory with byte strobes; read data registered, valid the cycle after the strobe.
module toy_mem_model import toy_mem_pkg::*; #(
    parameter int DATA_WIDTH = TOY_DATA_WIDTH,
    parameter int WORDS      = 64
) (
    input  logic               clk,
    toy_mem_req_adapter_if.mem bus
);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFS = (BW > 1) ? $clog2(BW) : 0;
    localparam int IW  = ptr_w(WORDS);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] mem_d [WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [IW-1:0]         idx;

    // Address aliases modulo the array size.
    assign idx = IW'(bus.mem_addr >> OFS);

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (bus.mem_en) begin
            if (bus.mem_wr_en) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.mem_wr_byte_en[b]) mem_d[idx][b*8 +: 8] = bus.mem_wr_data[b*8 +: 8];
                end
            end else begin
                rd_data_d = mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q     <= mem_d;
        rd_data_q <= rd_data_d;
    end

    assign bus.mem_rd_data = rd_data_q;

endmodule

// File: rtl/toy_resp_fifo.sv
// Response buffer: DEPTH entries, modulo-DEPTH pointers (any DEPTH), push into a full buffer is dropped.
module toy_resp_fifo import toy_mem_pkg::*; #(
    parameter int WIDTH = TOY_DATA_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = data_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (do_push) begin
            data_d[wr_ptr_q] = din;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: count/pointers gate every read of it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/toy_mem_req_adapter.sv
// Request/response adapter in front of a 1-cycle-latency memory with credit-based flow control.
// Define TOY_MEM_ADAPTER_WR_ACK_EN to make every accepted write return a zero-data response.
module toy_mem_req_adapter import toy_mem_pkg::*; #(
    parameter int ADDR_WIDTH = TOY_ADDR_WIDTH,
    parameter int DATA_WIDTH = TOY_DATA_WIDTH,
    parameter int RESP_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    toy_mem_req_adapter_if.adapter bus
);
    localparam int CW  = $clog2(RESP_DEPTH+1);
    localparam int CW1 = CW + 1;

    logic                  inflight_q, inflight_d;
    logic                  accept, rsp_needed, push, pop;
    logic                  fifo_empty, unused_fifo_full;
    logic [CW-1:0]         fifo_count;
    logic [CW1-1:0]        credit_used;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] fifo_dout;

    // Slots committed: buffered + the one arriving from memory, less the one leaving now.
    assign pop         = bus.resp_vld && bus.resp_rdy;
    assign credit_used = {1'b0, fifo_count} + CW1'(inflight_q) - CW1'(pop);
    assign bus.req_rdy = credit_used < CW1'(RESP_DEPTH);

    assign accept             = rst_n && bus.req_vld && bus.req_rdy;
    assign bus.mem_en         = accept;
    assign bus.mem_wr_en      = bus.req_wr_en;
    assign bus.mem_addr       = ADDR_WIDTH'(bus.req_addr);
    assign bus.mem_wr_data    = bus.req_wr_data;
    assign bus.mem_wr_byte_en = bus.req_wr_byte_en;

`ifdef TOY_MEM_ADAPTER_WR_ACK_EN
    logic inflight_wr_q, inflight_wr_d;

    assign rsp_needed = accept;
    assign push_data  = inflight_wr_q ? '0 : bus.mem_rd_data;

    always_comb inflight_wr_d = accept && bus.req_wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) inflight_wr_q <= 1'b0;
        else        inflight_wr_q <= inflight_wr_d;
    end
`else
    assign rsp_needed = accept && !bus.req_wr_en;
    assign push_data  = bus.mem_rd_data;
`endif

    always_comb inflight_d = rsp_needed;

    always_ff @(posedge clk) begin
        if (!rst_n) inflight_q <= 1'b0;
        else        inflight_q <= inflight_d;
    end

    // Memory data is valid exactly while inflight is set; a reset cycle discards it.
    assign push = inflight_q && rst_n;

    toy_resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (unused_fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.resp_vld  = !fifo_empty;
    assign bus.resp_data = fifo_dout;

endmodule

// File: tb/tb_toy_mem_req_adapter.sv
// Directed bench for toy_mem_req_adapter with toy_mem_model on the memory side.
module tb_toy_mem_req_adapter;
    import toy_mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toy_mem_req_adapter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    toy_mem_req_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    toy_mem_model #(.DATA_WIDTH(32), .WORDS(64)) u_mem (
        .clk (clk),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_wait;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          got_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            got_q.delete();
            got_cyc.delete();
        end else if (bus.resp_vld && bus.resp_rdy) begin
            got_q.push_back(bus.resp_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic toy_mem_req_t mk(input logic [31:0] a, input logic w,
                                        input logic [31:0] d, input logic [3:0] be);
        toy_mem_req_t r;
        r.addr = a; r.wr_en = w; r.wr_data = d; r.wr_byte_en = be;
        return r;
    endfunction

    task automatic drive(input toy_mem_req_t r);
        bus.req_vld        = 1'b1;
        bus.req_addr       = r.addr;
        bus.req_wr_en      = r.wr_en;
        bus.req_wr_data    = r.wr_data;
        bus.req_wr_byte_en = r.wr_byte_en;
    endtask

    // Present a request from the next falling edge until accepted; returns just after the accepting edge.
    task automatic issue(input toy_mem_req_t r, input logic [31:0] exp_rd);
        @(negedge clk);
        drive(r);
        #1;
        last_wait = 0;
        while (!bus.req_rdy && last_wait < 20) begin
            @(negedge clk); #1;
            last_wait++;
        end
        if (!bus.req_rdy) begin
            chk("req_rdy_timeout", bus.req_rdy, 1);
        end else begin
            chk("mem_en", bus.mem_en, 1);
            chk("mem_addr", bus.mem_addr, r.addr);
            if (!r.wr_en) exp_q.push_back(exp_rd);
`ifdef TOY_MEM_ADAPTER_WR_ACK_EN
            else exp_q.push_back(32'h0);
`endif
        end
        @(posedge clk);
        #1 bus.req_vld = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_resps(input string tag);
        chk({tag, "_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got_q.size()) ? {32'h0, got_q[i]} : 64'hx, exp_q[i]);
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    initial begin
        bus.req_vld = 1'b1; bus.req_addr = '0; bus.req_wr_en = 1'b0;
        bus.req_wr_data = '0; bus.req_wr_byte_en = '0; bus.resp_rdy = 1'b1;

        // Reset with a request pending: no memory strobe, clean state.
        repeat (3) @(negedge clk);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_resp_vld", bus.resp_vld, 0);
        bus.req_vld = 1'b0; rst_n = 1'b1;
        #1 chk("rst_req_rdy", bus.req_rdy, 1);

        // Full-word write then read, with latency check.
        issue(mk(32'h10, 1'b1, 32'hDEADBEEF, 4'hF), 32'h0);
        drain(4);
        issue(mk(32'h10, 1'b0, 32'h0, 4'h0), 32'hDEADBEEF);
        chk("lat_early_vld", bus.resp_vld, 0);
        @(posedge clk); #1;
        chk("lat_vld", bus.resp_vld, 1);
        chk("lat_data", bus.resp_data, 32'hDEADBEEF);
        drain(3);
        check_resps("rd_10");

        // Byte strobes.
        issue(mk(32'h20, 1'b1, 32'h11223344, 4'hF), 32'h0);
        issue(mk(32'h20, 1'b1, 32'h0000AA00, 4'h2), 32'h0);
        issue(mk(32'h20, 1'b0, 32'h0, 4'h0), 32'h1122AA44);
        issue(mk(32'h20, 1'b1, 32'hCC0000DD, 4'h9), 32'h0);
        issue(mk(32'h20, 1'b0, 32'h0, 4'h0), 32'hCC22AADD);
        drain(4);
        check_resps("byte_en");

        issue(mk(32'h0, 1'b1, 32'hA0A0A0A0, 4'hF), 32'h0);
        issue(mk(32'h4, 1'b1, 32'hB1B1B1B1, 4'hF), 32'h0);
        issue(mk(32'h8, 1'b1, 32'hC2C2C2C2, 4'hF), 32'h0);
        drain(4);
        check_resps("pre_fill");

        // Backpressure: two credits, third read waits for a pop.
        bus.resp_rdy = 1'b0;
        issue(mk(32'h0, 1'b0, 32'h0, 4'h0), 32'hA0A0A0A0);
        issue(mk(32'h4, 1'b0, 32'h0, 4'h0), 32'hB1B1B1B1);
        @(negedge clk);
        drive(mk(32'h8, 1'b0, 32'h0, 4'h0));
        #1;
        chk("full_rdy", bus.req_rdy, 0);
        chk("full_mem_en", bus.mem_en, 0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("full_hold_rdy", bus.req_rdy, 0);
            chk("full_head", bus.resp_data, 32'hA0A0A0A0);
        end
        bus.req_vld = 1'b0; #1;
        chk("rdy_indep_vld", bus.req_rdy, 0);
        bus.req_vld = 1'b1;
        @(negedge clk);
        bus.resp_rdy = 1'b1; #1;
        chk("release_rdy", bus.req_rdy, 1);
        chk("release_mem_en", bus.mem_en, 1);
        exp_q.push_back(32'hC2C2C2C2);
        @(posedge clk); #1 bus.req_vld = 1'b0;
        drain(4);
        check_resps("in_order");

        // Back-to-back reads with the consumer always ready.
        issue(mk(32'h0,  1'b0, 32'h0, 4'h0), 32'hA0A0A0A0); chk("b2b_rdy", last_wait, 0);
        issue(mk(32'h4,  1'b0, 32'h0, 4'h0), 32'hB1B1B1B1); chk("b2b_rdy", last_wait, 0);
        issue(mk(32'h8,  1'b0, 32'h0, 4'h0), 32'hC2C2C2C2); chk("b2b_rdy", last_wait, 0);
        issue(mk(32'h10, 1'b0, 32'h0, 4'h0), 32'hDEADBEEF); chk("b2b_rdy", last_wait, 0);
        drain(4);
        if (got_cyc.size() >= 4)
            for (int i = 1; i < 4; i++) chk("b2b_spacing", got_cyc[i] - got_cyc[i-1], 1);
        check_resps("b2b");

        // Reset with two buffered responses.
        bus.resp_rdy = 1'b0;
        issue(mk(32'h0, 1'b0, 32'h0, 4'h0), 32'hA0A0A0A0);
        issue(mk(32'h4, 1'b0, 32'h0, 4'h0), 32'hB1B1B1B1);
        drain(2);
        chk("buf_full_rdy", bus.req_rdy, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_buf_vld", bus.resp_vld, 0);
        chk("rst_buf_rdy", bus.req_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1; bus.resp_rdy = 1'b1;
        exp_q.delete();
        drain(5);
        chk("no_stale_vld", bus.resp_vld, 0);
        check_resps("post_rst");

        // Reset in the cycle the memory read completes.
        issue(mk(32'h8, 1'b0, 32'h0, 4'h0), 32'hC2C2C2C2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        drain(4);
        chk("mid_rst_vld", bus.resp_vld, 0);
        check_resps("mid_rst");

        issue(mk(32'h4, 1'b0, 32'h0, 4'h0), 32'hB1B1B1B1);
        drain(3);
        check_resps("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
